// File: rtl/bg_pkg.sv
// Shared types and constants for the affine background fetch path.
package bg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAP,
    TILE,
    DONE
  } fetch_state_t;

  localparam int unsigned SCR_BLOCK_BYTES  = 2048;
  localparam int unsigned CHAR_BLOCK_BYTES = 16384;
  localparam int unsigned TILE_BYTES_8BPP  = 64;

  // Square map edge length in pixels for a BGxCNT size code.
  function automatic logic [10:0] size_px(input logic [1:0] scr_size);
    return 11'd128 << scr_size;
  endfunction

endpackage

// File: rtl/bg_affine_addr_gen.sv
// Combinational range check, wraparound masking and map/tile address
// generation for one affine texel coordinate.
module bg_affine_addr_gen
  import bg_pkg::*;
#(
  parameter int unsigned VRAM_AW = 17
) (
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               overflow,
  input  logic [1:0]         scr_size,
  input  logic               wrap,
  input  logic [4:0]         scr_base,
  input  logic [1:0]         char_base,
  input  logic [7:0]         tile,
  output logic               out_of_range,
  output logic [VRAM_AW-1:0] map_addr,
  output logic [VRAM_AW-1:0] tile_addr
);

  logic [10:0] n_px;
  logic [9:0]  mask;
  logic [9:0]  xm;
  logic [9:0]  ym;
  logic [2:0]  row_shift;

  assign n_px = size_px(scr_size);
  assign mask = 10'(n_px - 11'd1);

  // Masking is harmless when wrap=0 and the coordinate is in range, so it is
  // applied unconditionally; negative two's-complement values wrap correctly.
  assign xm = x & mask;
  assign ym = y & mask;

  assign out_of_range = !wrap && (overflow || ({1'b0, x} >= n_px) || ({1'b0, y} >= n_px));

  // Tiles per row is 16 << scr_size, so the row offset is a shift.
  assign row_shift = 3'd4 + {1'b0, scr_size};

  assign map_addr = VRAM_AW'(scr_base) * VRAM_AW'(SCR_BLOCK_BYTES)
                  + (VRAM_AW'(ym[9:3]) << row_shift)
                  + VRAM_AW'(xm[9:3]);

  assign tile_addr = VRAM_AW'(char_base) * VRAM_AW'(CHAR_BLOCK_BYTES)
                   + VRAM_AW'(tile) * VRAM_AW'(TILE_BYTES_8BPP)
                   + VRAM_AW'({ym[2:0], xm[2:0]});

endmodule

// File: rtl/bg_affine_fetch.sv
// Affine BG (BG2/BG3) texel fetch: map entry read, then 8bpp tile texel read,
// returning one palette index per request.
// Optional feature: define BG_AFFINE_MAP_CACHE_EN for a one-entry map cache.
module bg_affine_fetch
  import bg_pkg::*;
#(
  parameter int unsigned VRAM_AW = 17,
  parameter int unsigned VRAM_DW = 16
) (
  input  logic               clock,
  input  logic               rst_b,
  input  logic               start,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               overflow,
  input  logic [1:0]         scr_size,
  input  logic               wrap,
  input  logic [4:0]         scr_base,
  input  logic [1:0]         char_base,
  output logic               vram_req,
  output logic [VRAM_AW-1:0] vram_addr,
  input  logic               vram_valid,
  input  logic [VRAM_DW-1:0] vram_rdata,
  output logic               busy,
  output logic               pix_valid,
  output logic [7:0]         pix_index,
  output logic               transparent
);

  fetch_state_t state_q, state_d;

  logic [9:0] x_q, y_q;
  logic       ovf_q, wrap_q;
  logic [1:0] size_q, char_base_q;
  logic [4:0] scr_base_q;
  logic [7:0] tile_q, pix_q;
  logic       transp_q;

  logic               idle;
  logic               out_of_range;
  logic [VRAM_AW-1:0] map_addr, tile_addr;
  logic [7:0]         map_byte, tile_byte;
  logic               cache_hit;
  logic [7:0]         cache_byte;

  assign idle = (state_q == IDLE);

  // In IDLE the live request is decoded so the accept cycle can branch;
  // afterwards the latched request drives the addresses.
  bg_affine_addr_gen #(
    .VRAM_AW (VRAM_AW)
  ) u_addr_gen (
    .x            (idle ? x : x_q),
    .y            (idle ? y : y_q),
    .overflow     (idle ? overflow : ovf_q),
    .scr_size     (idle ? scr_size : size_q),
    .wrap         (idle ? wrap : wrap_q),
    .scr_base     (idle ? scr_base : scr_base_q),
    .char_base    (idle ? char_base : char_base_q),
    .tile         (tile_q),
    .out_of_range (out_of_range),
    .map_addr     (map_addr),
    .tile_addr    (tile_addr)
  );

  assign map_byte  = map_addr[0] ? vram_rdata[15:8] : vram_rdata[7:0];
  assign tile_byte = tile_addr[0] ? vram_rdata[15:8] : vram_rdata[7:0];

`ifdef BG_AFFINE_MAP_CACHE_EN
  logic               cache_valid_q;
  logic [VRAM_AW-2:0] cache_haddr_q;
  logic [15:0]        cache_data_q;
  logic [4:0]         cache_sb_q;
  logic [1:0]         cache_sz_q;
  logic               cfg_match;

  assign cfg_match  = (cache_sb_q == scr_base) && (cache_sz_q == scr_size);
  assign cache_hit  = cache_valid_q && cfg_match && (cache_haddr_q == map_addr[VRAM_AW-1:1]);
  assign cache_byte = map_addr[0] ? cache_data_q[15:8] : cache_data_q[7:0];

  // Cache fill on every map read; drop the entry when the map layout changes.
  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      cache_valid_q <= 1'b0;
      cache_haddr_q <= '0;
      cache_data_q  <= '0;
      cache_sb_q    <= '0;
      cache_sz_q    <= '0;
    end else begin
      if (start && idle && !cfg_match) cache_valid_q <= 1'b0;
      if (state_q == MAP && vram_valid) begin
        cache_valid_q <= 1'b1;
        cache_haddr_q <= map_addr[VRAM_AW-1:1];
        cache_data_q  <= vram_rdata[15:0];
        cache_sb_q    <= scr_base_q;
        cache_sz_q    <= size_q;
      end
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_byte = 8'h00;
`endif

  // Next-state decode and VRAM request generation.
  always_comb begin
    state_d   = state_q;
    vram_req  = 1'b0;
    vram_addr = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (out_of_range)   state_d = DONE;
          else if (cache_hit) state_d = TILE; // map entry already known
          else                state_d = MAP;
        end
      end
      MAP: begin
        vram_req  = 1'b1;
        vram_addr = map_addr;
        if (vram_valid) state_d = TILE;
      end
      TILE: begin
        vram_req  = 1'b1;
        vram_addr = tile_addr;
        if (vram_valid) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Request capture, tile number latch and pixel result registers.
  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      x_q         <= '0;
      y_q         <= '0;
      ovf_q       <= 1'b0;
      wrap_q      <= 1'b0;
      size_q      <= '0;
      char_base_q <= '0;
      scr_base_q  <= '0;
      tile_q      <= '0;
      pix_q       <= '0;
      transp_q    <= 1'b1;
    end else begin
      if (start && idle) begin
        x_q         <= x;
        y_q         <= y;
        ovf_q       <= overflow;
        wrap_q      <= wrap;
        size_q      <= scr_size;
        char_base_q <= char_base;
        scr_base_q  <= scr_base;
        if (out_of_range) begin
          pix_q    <= 8'h00;
          transp_q <= 1'b1;
        end else if (cache_hit) begin
          tile_q <= cache_byte;
        end
      end
      if (state_q == MAP && vram_valid) tile_q <= map_byte;
      if (state_q == TILE && vram_valid) begin
        pix_q    <= tile_byte;
        transp_q <= (tile_byte == 8'h00);
      end
    end
  end

  assign busy        = !idle;
  assign pix_valid   = (state_q == DONE);
  assign pix_index   = pix_q;
  assign transparent = transp_q;

endmodule
